// File: rtl/plic_claim_arbiter.sv
// ---------------------------------------------------------------------------
// plic_claim_arbiter
//
// Core of the interrupt controller. Source lines are latched into pending
// bits through a gateway, the highest-priority enabled pending source above
// the threshold is selected and registered every cycle, and the target
// interrupt line is driven from that selection. A two-state claim FSM hands
// the selected ID to the register slave and marks it inflight. A complete
// strobe releases an inflight ID.
//
// Build option:
//   PLIC_EDGE_TRIG_EN  defined   -> gateway pends on 0->1 edges of irq_src
//                      undefined -> gateway pends on high level of irq_src
//
// Ports:
//   clk           clock
//   n_rst         asynchronous active-low reset
//   irq_src       raw source lines, bit i-1 = source ID i
//   src_prio      packed priorities, slice i-1 = source ID i
//   src_en        per-source enable
//   threshold     target threshold (strictly exceeded to interrupt)
//   claim_req     claim request, held until claim_ready
//   claim_ready   high in IDLE; claim accepted when claim_req is also high
//   claim_valid   one-cycle pulse, claim_id valid
//   claim_id      claimed ID (0 = nothing eligible), held until next claim
//   complete_req  one-cycle complete strobe
//   complete_id   ID being completed
//   pending       pending bits for readback
//   irq_out       interrupt to target
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for a claim; claim_ready high, irq_out may assert
//   RESP  | claim answered this cycle; best_* refreshes before next claim
// ---------------------------------------------------------------------------
module plic_claim_arbiter #(
    parameter  int NUM_SRC = 8,
    parameter  int PRIO_W  = 3,
    localparam int ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [NUM_SRC-1:0]        irq_src,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [PRIO_W-1:0]         threshold,
    input  logic                      claim_req,
    output logic                      claim_ready,
    output logic                      claim_valid,
    output logic [ID_W-1:0]           claim_id,
    input  logic                      complete_req,
    input  logic [ID_W-1:0]           complete_id,
    output logic [NUM_SRC-1:0]        pending,
    output logic                      irq_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t              state;
    logic [NUM_SRC-1:0]  inflight;
    logic [ID_W-1:0]     best_id;
    logic [PRIO_W-1:0]   best_prio;

    logic [PRIO_W-1:0]   prio_arr [NUM_SRC];
    logic [NUM_SRC-1:0]  eligible;
    logic [ID_W-1:0]     arb_id;
    logic [PRIO_W-1:0]   arb_prio;

    logic                claim_fire;
    logic [NUM_SRC-1:0]  claim_mask;
    logic [NUM_SRC-1:0]  complete_mask;
    logic [NUM_SRC-1:0]  trig;
    logic [NUM_SRC-1:0]  set_mask;
    logic [NUM_SRC-1:0]  pending_nxt;
    logic [NUM_SRC-1:0]  inflight_nxt;

    // ------------------------------------------------------------------
    // Eligibility and arbitration
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            prio_arr[i] = src_prio[i*PRIO_W +: PRIO_W];
        end
    end

    // Strict compare against threshold also excludes priority 0.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending[i] & src_en[i] & (prio_arr[i] > threshold);
        end
    end

    // Ascending scan with strict '>' keeps the lowest ID on a tie.
    always_comb begin
        arb_id   = '0;
        arb_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (prio_arr[i] > arb_prio)) begin
                arb_id   = ID_W'(i + 1);
                arb_prio = prio_arr[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Claim / complete decode
    // ------------------------------------------------------------------
    assign claim_fire = (state == IDLE) && claim_req;

    // best_id is always a pending source, never inflight, so a claim and a
    // complete in the same cycle can never collide on one bit.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_mask[i]    = claim_fire && (best_id == ID_W'(i + 1));
            complete_mask[i] = complete_req && (complete_id == ID_W'(i + 1));
        end
    end

    // ------------------------------------------------------------------
    // Gateway
    // ------------------------------------------------------------------
`ifdef PLIC_EDGE_TRIG_EN
    logic [NUM_SRC-1:0] irq_src_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            irq_src_q <= '0;
        end else begin
            irq_src_q <= irq_src;
        end
    end

    // Edges seen while pending or inflight are dropped by set_mask below.
    assign trig = irq_src & ~irq_src_q;
`else
    assign trig = irq_src;
`endif

    assign set_mask     = trig & ~pending & ~inflight;
    // A claim clearing a bit wins over a set on the same edge.
    assign pending_nxt  = (pending | set_mask) & ~claim_mask;
    // Clearing an ID that is not inflight is a no-op, which covers the
    // ignored cases (ID 0, out of range, not inflight) without extra logic.
    assign inflight_nxt = (inflight & ~complete_mask) | claim_mask;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pending   <= '0;
            inflight  <= '0;
            best_id   <= '0;
            best_prio <= '0;
        end else begin
            pending   <= pending_nxt;
            inflight  <= inflight_nxt;
            best_id   <= arb_id;
            best_prio <= arb_prio;
        end
    end

    // ------------------------------------------------------------------
    // Claim FSM with registered outputs. irq_out and claim_ready are
    // computed from the next state so they line up with state/best_id.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            claim_id    <= '0;
            claim_valid <= 1'b0;
            claim_ready <= 1'b1;
            irq_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (claim_req) begin
                        state       <= RESP;
                        claim_id    <= best_id;
                        claim_valid <= 1'b1;
                        claim_ready <= 1'b0;
                        irq_out     <= 1'b0;
                    end else begin
                        claim_valid <= 1'b0;
                        claim_ready <= 1'b1;
                        irq_out     <= (arb_id != '0);
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    claim_valid <= 1'b0;
                    claim_ready <= 1'b1;
                    irq_out     <= (arb_id != '0);
                end
                default: begin
                    state       <= IDLE;
                    claim_valid <= 1'b0;
                    claim_ready <= 1'b1;
                    irq_out     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plic_claim_arbiter.sv
module tb_plic_claim_arbiter;

    localparam int NS = 8;
    localparam int PW = 3;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              n_rst;
    logic [NS-1:0]     irq_src;
    logic [NS*PW-1:0]  src_prio;
    logic [NS-1:0]     src_en;
    logic [PW-1:0]     threshold;
    logic              claim_req;
    logic              claim_ready;
    logic              claim_valid;
    logic [IW-1:0]     claim_id;
    logic              complete_req;
    logic [IW-1:0]     complete_id;
    logic [NS-1:0]     pending;
    logic              irq_out;

    int n_checks = 0;
    int n_fail   = 0;

    plic_claim_arbiter #(.NUM_SRC(NS), .PRIO_W(PW)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .irq_src      (irq_src),
        .src_prio     (src_prio),
        .src_en       (src_en),
        .threshold    (threshold),
        .claim_req    (claim_req),
        .claim_ready  (claim_ready),
        .claim_valid  (claim_valid),
        .claim_id     (claim_id),
        .complete_req (complete_req),
        .complete_id  (complete_id),
        .pending      (pending),
        .irq_out      (irq_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: per-source flags indexed by ID 1..NS
    // ------------------------------------------------------------------
    bit m_pend [1:NS];
    bit m_infl [1:NS];
    bit m_srcq [1:NS];
    int m_best;
    bit m_resp;
    int m_cid;
    bit m_cv;

    function automatic int prio_of(input int id);
        return int'(src_prio[(id-1)*PW +: PW]);
    endfunction

    function automatic int model_pend_vec();
        int v = 0;
        for (int id = 1; id <= NS; id++) if (m_pend[id]) v += (1 << (id - 1));
        return v;
    endfunction

    task automatic model_reset();
        for (int id = 1; id <= NS; id++) begin
            m_pend[id] = 0; m_infl[id] = 0; m_srcq[id] = 0;
        end
        m_best = 0; m_resp = 0; m_cid = 0; m_cv = 0;
    endtask

    task automatic model_step();
        bit opend [1:NS];
        bit oinfl [1:NS];
        bit claimed [1:NS];
        int nb = 0;
        int np = 0;
        bool_rise_loop: begin end
        opend = m_pend;
        oinfl = m_infl;
        for (int id = 1; id <= NS; id++) begin
            claimed[id] = 0;
            if (opend[id] && src_en[id-1] && prio_of(id) > int'(threshold) && prio_of(id) > np) begin
                nb = id;
                np = prio_of(id);
            end
        end
        if (!m_resp && claim_req) begin
            m_cid  = m_best;
            m_cv   = 1;
            m_resp = 1;
            if (m_best != 0) begin
                claimed[m_best] = 1;
                m_infl[m_best]  = 1;
            end
        end else begin
            m_cv   = 0;
            m_resp = 0;
        end
        if (complete_req && complete_id >= 1 && complete_id <= NS && oinfl[complete_id])
            m_infl[complete_id] = 0;
        for (int id = 1; id <= NS; id++) begin
            bit trig;
`ifdef PLIC_EDGE_TRIG_EN
            trig = irq_src[id-1] && !m_srcq[id];
            m_srcq[id] = irq_src[id-1];
`else
            trig = irq_src[id-1];
`endif
            if (claimed[id]) m_pend[id] = 0;
            else if (trig && !opend[id] && !oinfl[id]) m_pend[id] = 1;
        end
        m_best = nb;
    endtask

    // One compare process: advance the model on each edge, check 2ns later.
    always begin
        @(posedge clk);
        if (!n_rst) model_reset();
        else        model_step();
        #2;
        chk("mon_pending",     int'(pending),     model_pend_vec());
        chk("mon_irq_out",     int'(irq_out),     int'(m_best != 0 && !m_resp));
        chk("mon_claim_ready", int'(claim_ready), int'(!m_resp));
        chk("mon_claim_valid", int'(claim_valid), int'(m_cv));
        chk("mon_claim_id",    int'(claim_id),    m_cid);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle_inputs();
        irq_src = '0; src_prio = '0; src_en = '0; threshold = '0;
        claim_req = 0; complete_req = 0; complete_id = '0;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic setup_3_5(input int thr);
        src_prio = '0;
        src_prio[2*PW +: PW] = 3'd2;
        src_prio[4*PW +: PW] = 3'd2;
        threshold = PW'(thr);
        src_en    = '1;
        irq_src   = 8'h14;
    endtask

    int exp_ready [3] = '{1, 0, 1};
    int pulses;
    int ids [2];

    initial begin
        n_rst = 1'b0;
        idle_inputs();
        model_reset();
        do_reset();
        chk("rst_pending", int'(pending), 0);
        chk("rst_ready", int'(claim_ready), 1);
        chk("rst_irq", int'(irq_out), 0);

        // Tie-break: IDs 3 and 5 at equal priority
        setup_3_5(1);
        @(negedge clk);
        chk("t2_pend_set", int'(pending), 8'h14);
        chk("t2_irq_lat", int'(irq_out), 0);
        @(negedge clk);
        chk("t2_irq_up", int'(irq_out), 1);
        claim_req = 1;
        @(negedge clk);
        chk("t2_cv1", int'(claim_valid), 1);
        chk("t2_id1", int'(claim_id), 3);
        chk("t2_rdy_resp", int'(claim_ready), 0);
        chk("t2_pend_clr", int'(pending), 8'h10);
        claim_req = 0;
        @(negedge clk);
        chk("t2_cv_drop", int'(claim_valid), 0);
        chk("t2_irq_5", int'(irq_out), 1);
        claim_req = 1;
        @(negedge clk);
        chk("t2_id2", int'(claim_id), 5);
        claim_req = 0;
        @(negedge clk);
        chk("t2_irq_off", int'(irq_out), 0);
        chk("t2_pend_0", int'(pending), 0);
        chk("t2_id_hold", int'(claim_id), 5);

        // Ignored completes, then a real complete of ID 3 (source held high)
        complete_req = 1; complete_id = 4'd0;
        @(negedge clk); complete_id = 4'd9;
        @(negedge clk); complete_id = 4'd4;
        @(negedge clk); complete_req = 0;
        @(negedge clk);
        chk("t4_ignored_pend", int'(pending), 0);
        chk("t4_ignored_irq", int'(irq_out), 0);
        complete_req = 1; complete_id = 4'd3;
        @(negedge clk);
        complete_req = 0;
        chk("t4_pend_wait", int'(pending), 0);
        @(negedge clk);
`ifdef PLIC_EDGE_TRIG_EN
        chk("t6_no_repend", int'(pending), 0);
        repeat (2) @(negedge clk);
        chk("t6_still_none", int'(irq_out), 0);
        irq_src[2] = 1'b0;
        @(negedge clk);
        irq_src[2] = 1'b1;
        @(negedge clk);
        chk("t6_repend", int'(pending), 8'h04);
        @(negedge clk);
        chk("t6_irq", int'(irq_out), 1);
`else
        chk("t4_repend", int'(pending), 8'h04);
        chk("t4_irq_lat", int'(irq_out), 0);
        @(negedge clk);
        chk("t4_irq", int'(irq_out), 1);
`endif

        // Threshold equal to priority: nothing eligible
        do_reset();
        setup_3_5(2);
        repeat (2) @(negedge clk);
        chk("t3_pend", int'(pending), 8'h14);
        chk("t3_irq", int'(irq_out), 0);
        claim_req = 1;
        @(negedge clk);
        claim_req = 0;
        chk("t3_cv", int'(claim_valid), 1);
        chk("t3_id0", int'(claim_id), 0);
        chk("t3_pend_kept", int'(pending), 8'h14);

        // claim_req held for three edges
        do_reset();
        setup_3_5(1);
        repeat (2) @(negedge clk);
        claim_req = 1;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            chk("t5_ready", int'(claim_ready), exp_ready[k]);
            @(negedge clk);
            if (claim_valid) begin
                if (pulses < 2) ids[pulses] = int'(claim_id);
                pulses++;
            end
        end
        claim_req = 0;
        @(negedge clk);
        chk("t5_cv_end", int'(claim_valid), 0);
        chk("t5_pulses", pulses, 2);
        chk("t5_id_a", ids[0], 3);
        chk("t5_id_b", ids[1], 5);

        // Reset asserted mid-claim
        do_reset();
        setup_3_5(1);
        repeat (2) @(negedge clk);
        claim_req = 1;
        @(negedge clk);
        chk("t1_in_resp", int'(claim_valid), 1);
        n_rst = 1'b0;
        claim_req = 0;
        #1;
        chk("t1_cv", int'(claim_valid), 0);
        chk("t1_id", int'(claim_id), 0);
        chk("t1_irq", int'(irq_out), 0);
        chk("t1_ready", int'(claim_ready), 1);
        chk("t1_pend", int'(pending), 0);
        @(negedge clk);
        n_rst = 1'b1;

        // Randomized traffic against the model
        src_prio  = 24'($urandom);
        src_en    = 8'($urandom);
        threshold = PW'($urandom_range(0, 3));
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_rst = 1'b1;
            for (int b = 0; b < NS; b++)
                if ($urandom_range(0, 5) == 0) irq_src[b] = ~irq_src[b];
            if ($urandom_range(0, 40) == 0) src_prio  = 24'($urandom);
            if ($urandom_range(0, 40) == 0) src_en    = 8'($urandom);
            if ($urandom_range(0, 60) == 0) threshold = PW'($urandom_range(0, 3));
            claim_req    = ($urandom_range(0, 2) == 0);
            complete_req = ($urandom_range(0, 2) == 0);
            complete_id  = IW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                for (int id = 1; id <= NS; id++)
                    if (m_infl[id] && $urandom_range(0, 1) == 0) complete_id = IW'(id);
            end
            if ($urandom_range(0, 499) == 0) n_rst = 1'b0;
        end
        @(negedge clk);
        n_rst = 1'b1;
        claim_req = 0;
        complete_req = 0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
